cpu_rst_seq: RTL and testbench
==============================

// Module: cpu_rst_seq
// PURPOSE
//  Parametrised reset/run controller for the pipelined MIPS core and its
//  peripherals. Takes one board-level reset and produces NUM_CH staggered,
//  synchronous active-high reset outputs released in order 0..NUM_CH-1.
//  Also provides a software reset request, a heartbeat watchdog that re-runs
//  the sequence on hang, and a run-cycle counter. Sits between the top-level
//  clock/reset source and the mips core plus its memories.
// PARAMETERS
//  NUM_CH      4     number of reset channels (>=1)
//  SYNC_STAGES 2     reset-deassert synchroniser depth (>=2)
//  HOLD_CYCLES 4     cycles all channels stay asserted after sync release (>=1)
//  STAGGER     2     cycles between successive channel releases (>=1)
//  WDT_CYCLES  1024  heartbeat-free RUN cycles before watchdog fires; 0 = off
//  CNT_W       32    width of run_cycles
// PORTS
//  clk         in   1         system clock, rising edge
//  reset       in   1         asynchronous, active-low reset
//  sw_rst_req  in   1         synchronous software reset request, 1-cycle pulse or level
//  heartbeat   in   1         core-alive strobe (e.g. retired-instruction pulse)
//  core_rst    out  NUM_CH    per-channel reset, active-high, synchronous to clk
//  ready       out  1         1 while in RUN (all channels released)
//  wdt_fired   out  1         sticky: watchdog has fired since last reset
//  run_cycles  out  CNT_W     rising edges spent in current RUN, saturating
//  state       out  2         00 ASSERT, 01 RELEASE, 10 RUN (debug)
// BEHAVIOUR
//  - reset low: immediately (async) core_rst=all 1, ready=0, wdt_fired=0,
//    run_cycles=0, state=ASSERT, counters=0, synchroniser flops=0.
//  - reset deassert passes SYNC_STAGES flops; HOLD counting starts after.
//    core_rst[0] falls on rising edge SYNC_STAGES+HOLD_CYCLES after the first
//    edge with reset high; state -> RELEASE on that edge.
//  - RELEASE: core_rst[i] falls exactly STAGGER edges after core_rst[i-1].
//    On the edge core_rst[NUM_CH-1] falls: state -> RUN, ready=1 same edge.
//    NUM_CH=1: ASSERT goes straight to RUN on the release edge.
//  - Once released, a channel stays 0 until the next re-sequence; no glitches.
//  - RUN: run_cycles +1 per edge, saturates at all-ones.
//    Watchdog counter +1 per edge with heartbeat=0, cleared to 0 on heartbeat=1.
//    When it would reach WDT_CYCLES: on that edge state -> ASSERT,
//    core_rst=all 1, ready=0, run_cycles=0, wdt_fired=1.
//  - sw_rst_req=1 sampled on any edge (any state): next state ASSERT,
//    core_rst=all 1 on that edge, hold counter restarts from 0.
//    Release then follows HOLD_CYCLES + stagger timing with no sync delay.
//    Held high: stays in ASSERT.
//  - Priority on the same edge: reset > sw_rst_req > watchdog > heartbeat.
//  - wdt_fired cleared only by reset, not by sw_rst_req.
//  - All counters sized by $clog2 of their limit; no wrap inside sequencing.
// TESTING
//  1 Defaults, reset low 3 cycles then high -> core_rst 1111 until edge 6;
//    bits clear one at edges 6,8,10,12; ready=1 at edge 12.
//  2 In RUN, heartbeat every 10 cycles for 5000 cycles -> ready stays 1,
//    wdt_fired=0, run_cycles tracks elapsed edges exactly.
//  3 WDT_CYCLES=16, heartbeat held 0 in RUN -> 16th edge: core_rst=1111,
//    wdt_fired=1, run_cycles=0; re-release starts 4 edges later.
//  4 sw_rst_req 1-cycle pulse mid-RELEASE, core_rst=1100 -> next edge 1111,
//    full re-sequence; heartbeat+sw_rst_req on same edge -> sw reset wins.
//  5 reset low mid-RUN, asynchronous between edges -> outputs reset at once;
//    wdt_fired cleared; normal sequence on release.
//  6 run_cycles with CNT_W=4 -> saturates at 15, no wrap.
//    NUM_CH=1, STAGGER=3 -> single release at edge SYNC+HOLD.

Source files
------------

// File: rtl/cpu_rst_seq.sv
// rtl/cpu_rst_seq.sv - staggered reset/run controller with software reset, watchdog and run counter
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low board reset
//   sw_rst_req  synchronous software reset request (pulse or level)
//   heartbeat   core-alive strobe, clears the watchdog in RUN
//   core_rst    per-channel active-high resets, released 0..NUM_CH-1
//   ready       1 while in RUN
//   wdt_fired   sticky watchdog flag, cleared only by reset
//   run_cycles  saturating count of rising edges spent in the current RUN
//   state       debug: 00 ASSERT, 01 RELEASE, 10 RUN
module cpu_rst_seq #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGGER     = 2,
  parameter int WDT_CYCLES  = 1024,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sw_rst_req,
  input  logic              heartbeat,
  output logic [NUM_CH-1:0] core_rst,
  output logic              ready,
  output logic              wdt_fired,
  output logic [CNT_W-1:0]  run_cycles,
  output logic [1:0]        state
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int STG_W  = (STAGGER > 1)     ? $clog2(STAGGER)     : 1;
  localparam int WDT_W  = (WDT_CYCLES > 1)  ? $clog2(WDT_CYCLES)  : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER - 1);
  localparam logic [WDT_W-1:0]  WDT_LAST  = WDT_W'(WDT_CYCLES - 1);
  // core_rst value just before the final channel is released
  localparam logic [NUM_CH-1:0] LAST_CH   = NUM_CH'(1) << (NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'b00,
    ST_RELEASE = 2'b01,
    ST_RUN     = 2'b10
  } st_t;

  st_t                    st;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [STG_W-1:0]       stg_cnt;
  logic [WDT_W-1:0]       wdt_cnt;

  assign state = st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= ST_ASSERT;
      sync_q     <= '0;
      hold_cnt   <= '0;
      stg_cnt    <= '0;
      wdt_cnt    <= '0;
      core_rst   <= '1;
      ready      <= 1'b0;
      wdt_fired  <= 1'b0;
      run_cycles <= '0;
    end else begin
      // Only the board reset clears the synchroniser, so software and
      // watchdog re-sequences skip the sync delay.
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};

      if (sw_rst_req) begin
        st         <= ST_ASSERT;
        hold_cnt   <= '0;
        stg_cnt    <= '0;
        wdt_cnt    <= '0;
        core_rst   <= '1;
        ready      <= 1'b0;
        run_cycles <= '0;
      end else begin
        case (st)
          ST_ASSERT: begin
            if (sync_q[SYNC_STAGES-1]) begin
              if (hold_cnt == HOLD_LAST) begin
                hold_cnt <= '0;
                stg_cnt  <= '0;
                // Channels release by shifting zeros in from bit 0.
                core_rst <= core_rst << 1;
                if (NUM_CH == 1) begin
                  st    <= ST_RUN;
                  ready <= 1'b1;
                end else begin
                  st <= ST_RELEASE;
                end
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
          end

          ST_RELEASE: begin
            if (stg_cnt == STG_LAST) begin
              stg_cnt  <= '0;
              core_rst <= core_rst << 1;
              if (core_rst == LAST_CH) begin
                st    <= ST_RUN;
                ready <= 1'b1;
              end
            end else begin
              stg_cnt <= stg_cnt + 1'b1;
            end
          end

          ST_RUN: begin
            if (WDT_CYCLES != 0 && !heartbeat && wdt_cnt == WDT_LAST) begin
              st         <= ST_ASSERT;
              hold_cnt   <= '0;
              wdt_cnt    <= '0;
              core_rst   <= '1;
              ready      <= 1'b0;
              wdt_fired  <= 1'b1;
              run_cycles <= '0;
            end else begin
              if (run_cycles != '1) run_cycles <= run_cycles + 1'b1;
              if (heartbeat || WDT_CYCLES == 0) wdt_cnt <= '0;
              else                              wdt_cnt <= wdt_cnt + 1'b1;
            end
          end

          default: st <= ST_ASSERT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_rst_seq.sv
// tb/tb_cpu_rst_seq.sv - scoreboard bench for cpu_rst_seq (4-channel watchdog instance and 1-channel saturating instance)
module tb_cpu_rst_seq;

  localparam logic [1:0] AS  = 2'b00;
  localparam logic [1:0] REL = 2'b01;
  localparam logic [1:0] RUN = 2'b10;

  typedef struct {
    int          cyc;
    logic [3:0]  rst;
    logic        rdy;
    logic        wdt;
    logic [1:0]  st;
    logic [31:0] rc;
  } item_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   b_done = 0;

  item_t qa[$];
  item_t qb[$];
  logic [7:0] prev [2];

  // instance A: four channels, short watchdog
  logic        rst_a, sw_a, hb_a;
  logic [3:0]  cr_a;
  logic        rdy_a, wf_a;
  logic [31:0] rc_a;
  logic [1:0]  st_a;

  // instance B: single channel, 4-bit run counter, watchdog off
  logic        rst_b, sw_b, hb_b;
  logic [0:0]  cr_b;
  logic        rdy_b, wf_b;
  logic [3:0]  rc_b;
  logic [1:0]  st_b;

  cpu_rst_seq #(.NUM_CH(4), .SYNC_STAGES(2), .HOLD_CYCLES(4), .STAGGER(2),
                .WDT_CYCLES(16), .CNT_W(32)) dut_a (
    .clk(clk), .reset(rst_a), .sw_rst_req(sw_a), .heartbeat(hb_a),
    .core_rst(cr_a), .ready(rdy_a), .wdt_fired(wf_a), .run_cycles(rc_a), .state(st_a));

  cpu_rst_seq #(.NUM_CH(1), .SYNC_STAGES(2), .HOLD_CYCLES(4), .STAGGER(3),
                .WDT_CYCLES(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(rst_b), .sw_rst_req(sw_b), .heartbeat(hb_b),
    .core_rst(cr_b), .ready(rdy_b), .wdt_fired(wf_b), .run_cycles(rc_b), .state(st_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int d, input int c, input logic [3:0] r, input logic rdy,
                      input logic w, input logic [1:0] s, input logic [31:0] rc);
    item_t it;
    it.cyc = c; it.rst = r; it.rdy = rdy; it.wdt = w; it.st = s; it.rc = rc;
    if (d == 0) qa.push_back(it);
    else        qb.push_back(it);
  endtask

  // Instance A release schedule starting with channel 0 at edge e0.
  task automatic exp_seq_a(input int e0, input logic w);
    push(0, e0,     4'b1110, 1'b0, w, REL, 0);
    push(0, e0 + 2, 4'b1100, 1'b0, w, REL, 0);
    push(0, e0 + 4, 4'b1000, 1'b0, w, REL, 0);
    push(0, e0 + 6, 4'b0000, 1'b1, w, RUN, 0);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic mon(input int d, input logic [3:0] r, input logic rdy, input logic w,
                     input logic [1:0] s, input logic [31:0] rc);
    item_t it;
    bit    have;
    string nm;
    have = 0;
    nm = (d == 0) ? "dut_a" : "dut_b";
    if (d == 0) begin
      if (qa.size() > 0 && qa[0].cyc == cyc) begin it = qa.pop_front(); have = 1; end
    end else begin
      if (qb.size() > 0 && qb[0].cyc == cyc) begin it = qb.pop_front(); have = 1; end
    end
    if (have) begin
      checks++;
      if (r !== it.rst || rdy !== it.rdy || w !== it.wdt || s !== it.st || rc !== it.rc) begin
        errors++;
        $display("FAIL %s edge %0d: got rst=%b rdy=%b wdt=%b st=%b rc=%0d, expected rst=%b rdy=%b wdt=%b st=%b rc=%0d",
                 nm, cyc, r, rdy, w, s, rc, it.rst, it.rdy, it.wdt, it.st, it.rc);
      end
    end else if ({r, rdy, w, s} !== prev[d]) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected_change edge %0d: got %b, expected unchanged %b",
               nm, cyc, {r, rdy, w, s}, prev[d]);
    end
    prev[d] = {r, rdy, w, s};
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      mon(0, cr_a, rdy_a, wf_a, st_a, rc_a);
      mon(1, {3'b000, cr_b}, rdy_b, wf_b, st_b, {28'd0, rc_b});
    end
  end

  // Instance B stimulus: single release at SYNC+HOLD, run counter saturation.
  initial begin
    int bb, e;
    rst_b = 1'b0; sw_b = 1'b0; hb_b = 1'b0;
    wait_cyc(2);
    push(1, 3, 4'h1, 1'b0, 1'b0, AS, 0);
    wait_cyc(4);
    rst_b = 1'b1;
    bb = cyc;
    e  = bb + 6;
    push(1, e,      4'h0, 1'b1, 1'b0, RUN, 0);
    push(1, e + 14, 4'h0, 1'b1, 1'b0, RUN, 14);
    push(1, e + 15, 4'h0, 1'b1, 1'b0, RUN, 15);
    push(1, e + 25, 4'h0, 1'b1, 1'b0, RUN, 15);
    wait_cyc(e + 30);
    b_done = 1;
  end

  // Instance A stimulus.
  initial begin
    int base, r, w, x, base2;
    prev[0] = {4'hF, 1'b0, 1'b0, AS};
    prev[1] = {4'h1, 1'b0, 1'b0, AS};
    rst_a = 1'b0; sw_a = 1'b0; hb_a = 1'b0;

    // power-on sequence
    wait_cyc(1);
    push(0, 2, 4'hF, 1'b0, 1'b0, AS, 0);
    wait_cyc(3);
    rst_a = 1'b1;
    base = cyc;
    exp_seq_a(base + 6, 1'b0);
    r = base + 12;

    // long RUN with heartbeat every 10 edges
    wait_cyc(r);
    for (int k = 0; k < 5000; k++) begin
      hb_a = ((k + 1) % 10 == 0);
      if ((k + 1) % 1000 == 0) push(0, r + k + 1, 4'h0, 1'b1, 1'b0, RUN, k + 1);
      @(negedge clk);
    end

    // heartbeat stops: watchdog fires on the 16th edge
    hb_a = 1'b0;
    w = r + 5016;
    push(0, w - 1, 4'h0,    1'b1, 1'b0, RUN, 5015);
    push(0, w,     4'hF,    1'b0, 1'b1, AS,  0);
    push(0, w + 4, 4'b1110, 1'b0, 1'b1, REL, 0);
    push(0, w + 6, 4'b1100, 1'b0, 1'b1, REL, 0);
    push(0, w + 7, 4'hF,    1'b0, 1'b1, AS,  0);

    // software reset pulse while core_rst = 1100
    wait_cyc(w + 6);
    sw_a = 1'b1;
    wait_cyc(w + 7);
    sw_a = 1'b0;
    exp_seq_a(w + 11, 1'b1);
    push(0, w + 19, 4'h0, 1'b1, 1'b1, RUN, 2);

    // heartbeat and software reset on the same edge, then held three edges
    x = w + 20;
    wait_cyc(x - 1);
    hb_a = 1'b1; sw_a = 1'b1;
    push(0, x, 4'hF, 1'b0, 1'b1, AS, 0);
    wait_cyc(x);
    hb_a = 1'b0;
    wait_cyc(x + 2);
    sw_a = 1'b0;
    exp_seq_a(x + 6, 1'b1);
    push(0, x + 15, 4'h0, 1'b1, 1'b1, RUN, 3);

    // asynchronous reset between edges in RUN
    wait_cyc(x + 15);
    push(0, x + 16, 4'hF, 1'b0, 1'b0, AS, 0);
    @(posedge clk);
    #2 rst_a = 1'b0;
    wait_cyc(x + 17);
    rst_a = 1'b1;
    base2 = cyc;
    exp_seq_a(base2 + 6, 1'b0);
    push(0, base2 + 17, 4'h0, 1'b1, 1'b0, RUN, 5);
    wait_cyc(base2 + 20);

    wait (b_done);
    @(negedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations: got %0d/%0d items never matched, expected 0/0",
               qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no end of stimulus by time %0t, expected completion", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
